clk_period_meter_32: RTL and testbench
======================================

# clk_period_meter_32

Measures the half-period of an asynchronous divided clock in `inclk` cycles and reports lock once the measurement is stable. It is the receiving end of the team's 32-bit clock divider: fed that divider's output, it recovers the programmed `div_clk_count`. It sits beside the divider for self-check and frequency reporting, and it also serves any externally supplied slow clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `sigclk`; minimum 2.
- `LOCK_COUNT`, default 4: number of consecutive identical measurements required to assert `locked`; minimum 1.

Ports:
- `inclk`  in  1  system clock; all logic is clocked on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `sigclk`  in  1  clock under measurement; asynchronous to `inclk`.
- `enable`  in  1  measurement enable; level-sensitive.
- `timeout_count`  in  32  `inclk` cycles without a `sigclk` edge before `lost` is declared; 0 disables the timeout.
- `half_period`  out  32  last measured interval between consecutive `sigclk` edges, in `inclk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `half_period` updates.
- `locked`  out  1  measurement stable.
- `lost`  out  1  sticky flag: timeout occurred; cleared by the next valid measurement or by `enable`=0.

## Operation
- `sigclk` passes through `SYNC_STAGES` flops, then one history flop. `edge` is asserted when the last two synchronized samples differ; both rising and falling edges count.
- Interval counter `cnt`, 32 bits:
  - loads 1 on an `edge` cycle;
  - increments on other cycles;
  - saturates at 0xFFFF_FFFF.
- On an `edge` cycle, the captured value is the current `cnt`, so edges detected N cycles apart yield N.
- State machine states: IDLE, ARM, MEASURE, LOCKED.
  - **IDLE:** entered while `enable`=0. `cnt` is held at 0, `locked`=0, `lost`=0, `match_cnt`=0. When `enable`=1, go to ARM.
  - **ARM:** the first `edge` starts counting and moves to MEASURE. No measurement is produced.
  - **MEASURE:** on each `edge`, capture into `half_period` and pulse `meas_valid`.
    - If the value equals the previous capture, `match_cnt`++. Otherwise `match_cnt` := 1. The first capture after ARM sets `match_cnt` := 1.
    - When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED and set `locked`=1.
  - **LOCKED:** captures continue.
    - A capture different from the previous one sets `match_cnt` := 1, clears `locked`, and returns to MEASURE.
    - An equal capture leaves `match_cnt` saturated.
- Timeout, in MEASURE or LOCKED: if `timeout_count`≠0 and `cnt` reaches `timeout_count` with no `edge`:
  - `lost`=1, `locked`=0, `half_period`=0, `match_cnt`=0;
  - go to ARM.
- In ARM, a timeout applies the same rule but is measured by a separate wait counter; this covers a dead clock at startup.
- Simultaneous `edge` and timeout in the same cycle: `edge` wins and the measurement is taken.
- `enable` deasserted in any state: next state IDLE. `half_period` holds its last value.
- Valid measurement after `lost`: `lost` clears in the same cycle `meas_valid` pulses.

## Timing
- Reset values: `half_period`=0, `meas_valid`=0, `locked`=0, `lost`=0. State = IDLE, and all synchronizer and history flops are 0.
- Reset asserted mid-operation forces these values immediately and asynchronously.
- Latency from a `sigclk` transition to `edge`: `SYNC_STAGES`+1 `inclk` cycles, with ±1 cycle of synchronizer uncertainty.
- `half_period`, `meas_valid`, `locked` and `lost` are registered and update in the cycle after `edge` is detected.
- Measurable range: half-period ≥ 2 `inclk` cycles. Shorter half-periods alias and are unsupported.
- `locked` asserts one cycle after the `LOCK_COUNT`-th consecutive identical capture.

## Structure
- Package `clk_meter_pkg`:
  - state enum (IDLE, ARM, MEASURE, LOCKED);
  - `MEAS_W`=32;
  - saturation constant.
- Sub-module `sync_edge_detect`, parameterized by `SYNC_STAGES`. Output: `edge` pulse. Reset: async active-low.
- Top level contains the counter, the comparator against the previous capture, and the FSM.

## Test plan
- Divider model, count 5, free-running, `LOCK_COUNT`=4 → `meas_valid` every 5 cycles with `half_period`=5; `locked`=1 after the 4th capture.
- Lock achieved, then divider count changed from 5 to 8 → `locked` drops on the first capture of 8; it re-locks after four captures of 8.
- Lock achieved, `sigclk` stopped, `timeout_count`=20 → 20 cycles after the last edge: `lost`=1, `locked`=0, `half_period`=0. Restarting `sigclk` clears `lost` on the first new measurement.
- Edge arrives on the exact cycle `cnt`=`timeout_count` → measurement taken, `lost` stays 0.
- `Reset_n` pulsed low mid-MEASURE → all outputs 0 immediately. After release with `enable`=1, the first edge produces no `meas_valid`; the second edge does.
- `enable` toggled 1→0→1 while locked → `locked`=0 and `half_period` held; no `meas_valid` until two edges after re-enable.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meter_pkg;

    localparam int MEAS_W = 32;
    localparam logic [MEAS_W-1:0] CNT_SAT = '1;
    localparam logic [MEAS_W-1:0] CNT_ONE = MEAS_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } meter_state_e;

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and flags any change (rising or falling)
// of the synchronized value for one clock cycle.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses non-blocking assignments and an async reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/clk_period_meter_32.sv
// Measures the half-period of an asynchronous clock in inclk cycles and reports
// lock once LOCK_COUNT consecutive measurements agree.
module clk_period_meter_32
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic              inclk,
    input  logic              Reset_n,
    input  logic              sigclk,
    input  logic              enable,
    input  logic [MEAS_W-1:0] timeout_count,
    output logic [MEAS_W-1:0] half_period,
    output logic              meas_valid,
    output logic              locked,
    output logic              lost
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    meter_state_e      state_q;
    logic [MEAS_W-1:0] cnt_q, cnt_d;
    logic [MEAS_W-1:0] wait_q, wait_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MEAS_W-1:0] half_period_q;
    logic              meas_valid_q, locked_q, lost_q;
    logic              sig_edge;
    logic              timeout_hit;
    logic              timeout_en;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (inclk),
        .rst_n  (Reset_n),
        .async_i(sigclk),
        .edge_o (sig_edge)
    );

    assign timeout_en = (timeout_count != '0);

    // ARM uses its own wait counter so a clock that never starts is still caught.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d       = '0;
        wait_d      = '0;
        timeout_hit = 1'b0;
        case (state_q)
            ARM: begin
                cnt_d       = sig_edge ? CNT_ONE : '0;
                wait_d      = sig_edge ? '0 : sat_inc(wait_q);
                timeout_hit = timeout_en && !sig_edge && (wait_q >= timeout_count);
            end
            MEASURE, LOCKED: begin
                cnt_d       = sig_edge ? CNT_ONE : sat_inc(cnt_q);
                timeout_hit = timeout_en && !sig_edge && (cnt_q >= timeout_count);
            end
            default: ;
        endcase
        if (!enable || timeout_hit) begin
            cnt_d  = '0;
            wait_d = '0;
        end
    end

    // match_q of zero marks the first capture after ARM, which has nothing to compare against.
    always_comb begin
        match_d = MATCH_ONE;
        if (match_q != '0 && cnt_q == half_period_q) begin
            match_d = (match_q == LOCK_MATCH) ? match_q : match_q + MATCH_ONE;
        end
    end

    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wait_q        <= '0;
            match_q       <= '0;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            meas_valid_q <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                match_q  <= '0;
                locked_q <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: begin
                        if (sig_edge) begin
                            state_q <= MEASURE;
                        end else if (timeout_hit) begin
                            lost_q        <= 1'b1;
                            locked_q      <= 1'b0;
                            half_period_q <= '0;
                            match_q       <= '0;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (sig_edge) begin
                            half_period_q <= cnt_q;
                            meas_valid_q  <= 1'b1;
                            lost_q        <= 1'b0;
                            match_q       <= match_d;
                            if (match_d == LOCK_MATCH) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q  <= MEASURE;
                                locked_q <= 1'b0;
                            end
                        end else if (timeout_hit) begin
                            state_q       <= ARM;
                            lost_q        <= 1'b1;
                            locked_q      <= 1'b0;
                            half_period_q <= '0;
                            match_q       <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign half_period = half_period_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_clk_period_meter_32.sv
// Self-checking bench for clk_period_meter_32: sigclk is driven as a divided clock
// and every capture is compared against a model built from the edge timestamps.
module tb_clk_period_meter_32;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_COUNT  = 4;
    localparam int SETTLE      = SYNC_STAGES + 2;

    logic        inclk = 1'b0;
    logic        Reset_n;
    logic        sigclk = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] timeout_count = '0;
    logic [31:0] half_period;
    logic        meas_valid, locked, lost;

    clk_period_meter_32 #(
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .inclk        (inclk),
        .Reset_n      (Reset_n),
        .sigclk       (sigclk),
        .enable       (enable),
        .timeout_count(timeout_count),
        .half_period  (half_period),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 inclk = ~inclk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    always @(posedge inclk) cyc++;

    typedef struct {
        logic [31:0] hp;
        logic        lk;
        logic        ls;
        longint      t;
    } cap_t;

    cap_t        obs_q[$];
    logic [31:0] exp_hp_q[$];
    bit          exp_lk_q[$];
    longint      last_mv_t = 0;
    bit          lost_seen = 0;

    always @(negedge inclk) begin
        cap_t c;
        if (meas_valid === 1'b1) begin
            c.hp = half_period;
            c.lk = locked;
            c.ls = lost;
            c.t  = cyc;
            obs_q.push_back(c);
            last_mv_t = cyc;
        end
        if (lost === 1'b1) lost_seen = 1'b1;
    end

    // Reference model: the half-period is the spacing between sigclk toggles;
    // locked holds while the current run of equal captures is LOCK_COUNT or longer.
    bit          m_armed = 0;
    int          m_run   = 0;
    logic [31:0] m_prev  = '0;
    longint      m_last_t = 0;

    function automatic void model_rearm();
        m_armed = 0;
        m_run   = 0;
    endfunction

    function automatic void model_edge();
        logic [31:0] iv;
        iv = 32'(cyc - m_last_t);
        m_last_t = cyc;
        if (!m_armed) begin
            m_armed = 1;
        end else begin
            if (m_run > 0 && iv == m_prev) m_run++;
            else m_run = 1;
            m_prev = iv;
            exp_hp_q.push_back(iv);
            exp_lk_q.push_back(m_run >= LOCK_COUNT);
        end
    endfunction

    task automatic toggle_after(input int n);
        repeat (n) @(negedge inclk);
        sigclk = ~sigclk;
        model_edge();
    endtask

    task automatic test_reset();
        n_checks++;
        if (half_period !== 32'd0 || meas_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0)
            $display("FAIL reset_outputs: got hp=%0d mv=%b lk=%b lost=%b, expected all 0",
                     half_period, meas_valid, locked, lost);
        else n_pass++;
        repeat (3) @(negedge inclk);
        Reset_n = 1'b1;
        repeat (2) @(negedge inclk);
        n_checks++;
        if (meas_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0)
            $display("FAIL reset_idle: got mv=%b lk=%b lost=%b after release, expected 0",
                     meas_valid, locked, lost);
        else n_pass++;
    endtask

    task automatic test_arm_timeout();
        bit got = 0;
        timeout_count = 32'd15;
        enable = 1'b1;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge inclk);
            if (lost === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || half_period !== 32'd0 || locked !== 1'b0 || obs_q.size() != 0)
            $display("FAIL arm_timeout: got lost_seen=%b hp=%0d lk=%b caps=%0d, expected 1/0/0/0",
                     got, half_period, locked, obs_q.size());
        else n_pass++;
        enable = 1'b0;
        repeat (2) @(negedge inclk);
        n_checks++;
        if (lost !== 1'b0) $display("FAIL arm_lost_clear: got lost=%b, expected 0", lost);
        else n_pass++;
        timeout_count = '0;
    endtask

    task automatic test_lock_basic();
        model_rearm();
        enable = 1'b1;
        repeat (2) @(negedge inclk);
        toggle_after(3);
        for (int i = 0; i < 6; i++) toggle_after(5);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL basic_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL basic_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (obs_q[i].t - obs_q[i-1].t != 5)
                    $display("FAIL basic_spacing%0d: got %0d cycles, expected 5", i, obs_q[i].t - obs_q[i-1].t);
                else n_pass++;
            end
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    task automatic test_relock();
        toggle_after(8 - SETTLE);
        for (int i = 0; i < 4; i++) toggle_after(8);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL relock_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL relock_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    task automatic test_edge_at_timeout();
        lost_seen = 0;
        toggle_after(5);
        repeat (4) @(negedge inclk);
        timeout_count = 32'd5;
        toggle_after(1);
        for (int i = 0; i < 5; i++) toggle_after(5);
        repeat (3) @(negedge inclk);
        timeout_count = '0;
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (lost_seen !== 1'b0) $display("FAIL edge_at_timeout_lost: got lost=1, expected 0");
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL eat_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL eat_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    task automatic test_timeout();
        bit     got = 0;
        longint t_lost = 0;
        timeout_count = 32'd20;
        for (int i = 0; i < 6; i++) toggle_after(5);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (locked !== 1'b1 || !(m_run >= LOCK_COUNT))
            $display("FAIL timeout_prelock: got lk=%b, expected 1", locked);
        else n_pass++;
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge inclk);
            if (lost === 1'b1) begin
                got    = 1;
                t_lost = cyc;
            end
        end
        n_checks++;
        if (!got || t_lost - last_mv_t != 20)
            $display("FAIL timeout_delay: got lost=%b after %0d cycles, expected 1 after 20",
                     got, t_lost - last_mv_t);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0 || half_period !== 32'd0)
            $display("FAIL timeout_outputs: got lk=%b hp=%0d, expected 0/0", locked, half_period);
        else n_pass++;
        model_rearm();
        toggle_after(2);
        repeat (4) @(negedge inclk);
        n_checks++;
        if (lost !== 1'b1 || obs_q.size() != 0)
            $display("FAIL timeout_arm_hold: got lost=%b caps=%0d, expected 1/0", lost, obs_q.size());
        else n_pass++;
        toggle_after(1);
        toggle_after(5);
        toggle_after(5);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size() || obs_q.size() == 0)
            $display("FAIL restart_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++;
            if (obs_q[0].ls !== 1'b0) $display("FAIL restart_lost_clear: got lost=%b, expected 0", obs_q[0].ls);
            else n_pass++;
        end
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL restart_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
        timeout_count = '0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) toggle_after(7);
        repeat (SETTLE) @(negedge inclk);
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
        @(negedge inclk);
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (half_period !== 32'd0 || meas_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0)
            $display("FAIL reset_mid: got hp=%0d mv=%b lk=%b lost=%b, expected all 0",
                     half_period, meas_valid, locked, lost);
        else n_pass++;
        sigclk = 1'b0;
        repeat (2) @(negedge inclk);
        Reset_n = 1'b1;
        model_rearm();
        repeat (2) @(negedge inclk);
        toggle_after(3);
        toggle_after(7);
        toggle_after(7);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL reset_mid_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL reset_mid_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    task automatic test_enable_toggle();
        for (int i = 0; i < 5; i++) toggle_after(7);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (locked !== 1'b1 || !(m_run >= LOCK_COUNT))
            $display("FAIL enable_prelock: got lk=%b, expected 1", locked);
        else n_pass++;
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
        enable = 1'b0;
        repeat (3) @(negedge inclk);
        n_checks++;
        if (locked !== 1'b0 || half_period !== m_prev || lost !== 1'b0)
            $display("FAIL enable_off: got lk=%b hp=%0d lost=%b, expected 0/%0d/0",
                     locked, half_period, lost, m_prev);
        else n_pass++;
        enable = 1'b1;
        model_rearm();
        repeat (2) @(negedge inclk);
        toggle_after(3);
        toggle_after(6);
        toggle_after(6);
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL reenable_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL reenable_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    task automatic test_random();
        int iv = 9;
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(3, 0) == 0) iv = int'($urandom_range(30, 2));
            toggle_after(iv);
        end
        repeat (SETTLE) @(negedge inclk);
        n_checks++;
        if (obs_q.size() != exp_hp_q.size())
            $display("FAIL random_count: got %0d captures, expected %0d", obs_q.size(), exp_hp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_hp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].hp !== exp_hp_q[i] || obs_q[i].lk !== exp_lk_q[i])
                $display("FAIL random_cap%0d: got hp=%0d lk=%b, expected hp=%0d lk=%b",
                         i, obs_q[i].hp, obs_q[i].lk, exp_hp_q[i], exp_lk_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_hp_q.delete(); exp_lk_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #2;
        test_reset();
        test_arm_timeout();
        test_lock_basic();
        test_relock();
        test_edge_at_timeout();
        test_timeout();
        test_reset_mid();
        test_enable_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
